// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch port, data port and memory port of the arbiter in one bundle.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    logic              bus_err;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, bus_err
    );

    // Requester / memory side (CPU plus memory model).
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, bus_err
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a tie goes to the port that did not win last.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic       grant_c
);

    // Pick the granted index; req[0] is fetch, req[1] is data.
    always_comb begin
        grant_c = GNT_IF;
        if (enable) begin
            case (req)
                2'b01:   grant_c = GNT_IF;
                2'b10:   grant_c = GNT_D;
                2'b11:   grant_c = ~last_grant;
                default: grant_c = GNT_IF;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory between the CPU fetch and load/store ports.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic              gnt, gnt_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic              any_req;
    logic              grant_c;

    logic              m_req_q, m_req_nxt;
    logic              m_we_q, m_we_nxt;
    logic [ADDR_W-1:0] m_addr_q, m_addr_nxt;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_nxt;
    logic              if_ack_q, if_ack_nxt;
    logic              d_ack_q, d_ack_nxt;
    logic              bus_err_q, bus_err_nxt;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_nxt;

    assign any_req = bus.if_req | bus.d_req;

    arb_rr2 u_arb (
        .req        ({bus.d_req, bus.if_req}),
        .last_grant (last_grant),
        .enable     (state == ST_IDLE),
        .grant_c    (grant_c)
    );

    // State, bookkeeping and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GNT_D;
            gnt        <= GNT_IF;
            wait_cnt   <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            gnt        <= gnt_nxt;
            wait_cnt   <= wait_cnt_nxt;
            m_req_q    <= m_req_nxt;
            m_we_q     <= m_we_nxt;
            m_addr_q   <= m_addr_nxt;
            m_wdata_q  <= m_wdata_nxt;
            if_ack_q   <= if_ack_nxt;
            d_ack_q    <= d_ack_nxt;
            bus_err_q  <= bus_err_nxt;
            if_rdata_q <= if_rdata_nxt;
            d_rdata_q  <= d_rdata_nxt;
        end
    end

    // Next-state: IDLE -> BUSY on any request, BUSY -> RESP on ack or timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = ST_BUSY;
            ST_BUSY: if (bus.m_ack || wait_cnt == WAIT_LAST) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; acks and bus_err default low so they pulse.
    always_comb begin
        last_grant_nxt = last_grant;
        gnt_nxt        = gnt;
        wait_cnt_nxt   = wait_cnt;
        m_req_nxt      = m_req_q;
        m_we_nxt       = m_we_q;
        m_addr_nxt     = m_addr_q;
        m_wdata_nxt    = m_wdata_q;
        if_ack_nxt     = 1'b0;
        d_ack_nxt      = 1'b0;
        bus_err_nxt    = 1'b0;
        if_rdata_nxt   = if_rdata_q;
        d_rdata_nxt    = d_rdata_q;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_nxt        = grant_c;
                    last_grant_nxt = grant_c;
                    wait_cnt_nxt   = '0;
                    m_req_nxt      = 1'b1;
                    if (grant_c == GNT_IF) begin
                        m_we_nxt    = 1'b0;
                        m_addr_nxt  = bus.if_addr;
                        m_wdata_nxt = '0;
                    end else begin
                        m_we_nxt    = bus.d_we;
                        m_addr_nxt  = bus.d_addr;
                        m_wdata_nxt = bus.d_wdata;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.m_ack || wait_cnt == WAIT_LAST) begin
                    m_req_nxt   = 1'b0;
                    bus_err_nxt = ~bus.m_ack;
                    if (gnt == GNT_IF) begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = bus.m_ack ? bus.m_rdata : '0;
                    end else begin
                        d_ack_nxt = 1'b1;
                        if (!m_we_q) d_rdata_nxt = bus.m_ack ? bus.m_rdata : '0;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.if_ack   = if_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with hand-computed expectations.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int busy_cycles;
        rst         = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_rdata = '0;
        bus.m_ack   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_m_req",    32'(bus.m_req),   32'd0);
        check("rst_m_addr",   bus.m_addr,       32'd0);
        check("rst_if_ack",   32'(bus.if_ack),  32'd0);
        check("rst_d_ack",    32'(bus.d_ack),   32'd0);
        check("rst_bus_err",  32'(bus.bus_err), 32'd0);
        check("rst_if_rdata", bus.if_rdata,     32'd0);
        check("rst_d_rdata",  bus.d_rdata,      32'd0);

        // Fetch only, zero-wait memory
        bus.if_addr = 32'h40;
        bus.if_req  = 1'b1;
        tick();
        check("f_m_req",  32'(bus.m_req), 32'd1);
        check("f_m_addr", bus.m_addr,     32'h40);
        check("f_m_we",   32'(bus.m_we),  32'd0);
        check("f_if_ack_early", 32'(bus.if_ack), 32'd0);
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h2408_0005;
        tick();
        check("f_if_ack",   32'(bus.if_ack),  32'd1);
        check("f_if_rdata", bus.if_rdata,     32'h2408_0005);
        check("f_m_req_off", 32'(bus.m_req),  32'd0);
        check("f_d_ack",    32'(bus.d_ack),   32'd0);
        check("f_bus_err",  32'(bus.bus_err), 32'd0);
        bus.m_ack  = 1'b0;
        bus.if_req = 1'b0;
        tick();
        check("f_if_ack_pulse", 32'(bus.if_ack), 32'd0);
        check("f_if_rdata_hold", bus.if_rdata,   32'h2408_0005);

        // Load, zero-wait memory
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h180;
        tick();
        check("ld_m_addr", bus.m_addr,    32'h180);
        check("ld_m_we",   32'(bus.m_we), 32'd0);
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h1122_3344;
        tick();
        check("ld_d_ack",   32'(bus.d_ack),  32'd1);
        check("ld_d_rdata", bus.d_rdata,     32'h1122_3344);
        check("ld_if_ack",  32'(bus.if_ack), 32'd0);
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        tick();

        // Store with three wait cycles; latched fields held despite input changes
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h100;
        bus.d_wdata = 32'hCAFE_F00D;
        tick();
        bus.d_wdata = 32'h0BAD_0BAD;
        bus.d_addr  = 32'h999;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("st_m_req_%0d", i),   32'(bus.m_req), 32'd1);
            check($sformatf("st_m_we_%0d", i),    32'(bus.m_we),  32'd1);
            check($sformatf("st_m_addr_%0d", i),  bus.m_addr,     32'h100);
            check($sformatf("st_m_wdata_%0d", i), bus.m_wdata,    32'hCAFE_F00D);
            check($sformatf("st_d_ack_%0d", i),   32'(bus.d_ack), 32'd0);
            if (i == 3) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = 32'h5555_AAAA;
            end
            tick();
        end
        check("st_d_ack",   32'(bus.d_ack), 32'd1);
        check("st_d_rdata", bus.d_rdata,    32'h1122_3344);
        check("st_m_req_off", 32'(bus.m_req), 32'd0);
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();
        check("st_d_ack_once", 32'(bus.d_ack), 32'd0);

        // Tie after reset: strict alternation starting with fetch
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.if_addr = 32'h200;
        bus.d_addr  = 32'h300;
        bus.d_we    = 1'b0;
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("tie_m_addr_%0d", i), bus.m_addr,
                  (i % 2 == 0) ? 32'h200 : 32'h300);
            bus.m_ack   = 1'b1;
            bus.m_rdata = 32'(i + 1);
            tick();
            check($sformatf("tie_if_ack_%0d", i), 32'(bus.if_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("tie_d_ack_%0d", i),  32'(bus.d_ack),  (i % 2 == 0) ? 32'd0 : 32'd1);
            bus.m_ack = 1'b0;
            tick();
        end
        check("tie_if_rdata", bus.if_rdata, 32'd3);
        check("tie_d_rdata",  bus.d_rdata,  32'd4);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();

        // Timeout on a load: m_req for 16 cycles, then error ack with zero data
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h80;
        tick();
        busy_cycles = 0;
        while (bus.m_req === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            tick();
        end
        check("to_busy_cycles", 32'(busy_cycles), 32'd16);
        check("to_d_ack",   32'(bus.d_ack),   32'd1);
        check("to_bus_err", 32'(bus.bus_err), 32'd1);
        check("to_d_rdata", bus.d_rdata,      32'd0);
        bus.d_req = 1'b0;
        tick();
        check("to_bus_err_pulse", 32'(bus.bus_err), 32'd0);
        check("to_d_ack_pulse",   32'(bus.d_ack),   32'd0);

        // Reset in the second BUSY cycle aborts the access; fetch wins the next tie
        bus.if_addr = 32'h44;
        bus.if_req  = 1'b1;
        tick();
        tick();
        check("rm_m_req_busy2", 32'(bus.m_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_m_req",  32'(bus.m_req),  32'd0);
        check("rm_if_ack", 32'(bus.if_ack), 32'd0);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h300;
        tick();
        check("rm_grant_if", bus.m_addr, 32'h44);
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h7777_0001;
        tick();
        check("rm_if_ack2", 32'(bus.if_ack), 32'd1);
        check("rm_d_ack2",  32'(bus.d_ack),  32'd0);
        bus.m_ack  = 1'b0;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();

        // Spurious m_ack in IDLE and RESP is ignored
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hABCD_1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sp_idle_m_req_%0d", i), 32'(bus.m_req),  32'd0);
            check($sformatf("sp_idle_ack_%0d", i),   32'({bus.if_ack, bus.d_ack}), 32'd0);
        end
        check("sp_if_rdata_hold", bus.if_rdata, 32'h7777_0001);
        bus.if_addr = 32'h48;
        bus.if_req  = 1'b1;
        tick();
        check("sp_busy_m_req", 32'(bus.m_req), 32'd1);
        tick();
        check("sp_if_ack",   32'(bus.if_ack), 32'd1);
        check("sp_if_rdata", bus.if_rdata,    32'hABCD_1234);
        bus.if_req = 1'b0;
        tick();
        check("sp_resp_if_ack", 32'(bus.if_ack), 32'd0);
        check("sp_resp_m_req",  32'(bus.m_req),  32'd0);
        tick();
        check("sp_after_m_req", 32'(bus.m_req),  32'd0);
        check("sp_after_ack",   32'({bus.if_ack, bus.d_ack}), 32'd0);
        bus.m_ack = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported unified memory between the multi-cycle CPU's instruction-fetch port and its load/store data port.
- Each requester uses a level-request / one-cycle-ack handshake. The arbiter latches the winning request, drives the memory port until the memory acks, then returns the read data to the winner.
- Two-requester round-robin fairness and a per-access timeout are built in.
- Sits between the CPU top level and the memory model / bus bridge.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT, 16, memory-wait cycles before an access is aborted with error; legal range 2..255

Ports:
clk  in  1  clock
rst  in  1  reset; rst synchronous, active-high; clock clk
if_req  in  1  fetch request, held high until if_ack
if_addr  in  ADDR_W  fetch address, stable while if_req high
if_rdata  out  DATA_W  fetch data, valid when if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held high until d_ack
d_we  in  1  1=store, 0=load; stable while d_req high
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid when d_ack=1
d_ack  out  1  one-cycle data completion pulse
m_req  out  1  memory request, held until m_ack or timeout
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid with m_ack
m_ack  in  1  memory completion, may assert in the first m_req cycle
bus_err  out  1  one-cycle pulse coincident with an ack caused by timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=DATA; wait counter 0. A reset during any state aborts the access: m_req=0 from the next cycle, no ack is issued.
- All outputs are registered.
- States:
  - IDLE: sample if_req/d_req.
    - Exactly one request high: grant it.
    - Both high: grant the one not equal to last_grant (first tie after reset goes to IF).
    - On grant: latch addr/we/wdata (m_we forced 0 for IF), go to BUSY, set m_req=1 next cycle, update last_grant.
  - BUSY: m_req=1 and m_addr/m_we/m_wdata held from the latch, regardless of requester input changes.
    - On m_ack: capture m_rdata, go to RESP.
    - Otherwise increment the wait counter. When it reaches TIMEOUT-1 with no m_ack: go to RESP with error, captured data forced to 0.
  - RESP: m_req=0. Pulse the granted requester's ack (and bus_err if timed out). Drive its rdata from the captured value. Go to IDLE. Requests are ignored in RESP.
- Latency: request sampled at the end of cycle k → m_req high in k+1. m_ack sampled in cycle j → ack and rdata in j+1. Minimum request-to-ack is 3 cycles with zero-wait memory.
- rdata registers update only on that port's ack:
  - if_rdata/d_rdata hold their previous value otherwise.
  - d_rdata is unchanged on store acks; stores never return data.
- Requester protocol: drop req in the cycle after ack. The arbiter re-samples in IDLE, so a held req is treated as a new request.
- m_ack outside BUSY is ignored.
- Wait counter width is 8 bits; it clears on entry to BUSY.
- Only one memory access is outstanding at any time. Strict alternation holds when both ports request continuously.

Decomposition:
- Shared package mem_arb_pkg: state encoding (IDLE, BUSY, RESP), grant-ID constants (GNT_IF=0, GNT_D=1), default TIMEOUT.
- One sub-module, arb_rr2: 2-way round-robin picker. Inputs: req[1:0], last_grant, enable. Output: grant index, combinational. It is instantiated once.

Test Plan:
- Fetch only: if_req at addr 0x40, memory acks in 1st BUSY cycle returning 0x24080005 → if_ack in cycle 3 after request, if_rdata=0x24080005, m_we=0 throughout.
- Store: d_req, d_we=1, addr 0x100, wdata 0xCAFEF00D, memory waits 3 cycles → m_addr/m_wdata stable for 4 cycles, d_ack once, d_rdata unchanged.
- Tie after reset: if_req and d_req both high in the same cycle, held continuously → grants IF, D, IF, D; no port acked twice in a row.
- Timeout: d_req load, m_ack never asserted, TIMEOUT=16 → m_req high exactly 16 cycles, then d_ack=1, bus_err=1, d_rdata=0.
- Reset mid-access: rst in the 2nd BUSY cycle → m_req=0 next cycle, no ack; next IF request after reset is granted first.
- Spurious m_ack in IDLE/RESP → no state change, no ack.
